// File: rtl/fp_wire_pkg.sv
// fp_wire: shared widths and record types for the arbitrated multiply-accumulate datapath
package fp_wire;
  localparam int RES_W = 110;
  localparam int OPD_W = 56;
  localparam int SHF_W = RES_W - OPD_W;
  typedef struct packed {
    logic             valid;
    logic [OPD_W-1:0] a;
    logic [OPD_W-1:0] b;
    logic [OPD_W-1:0] c;
    logic             op;
  } arb_req_t;
  typedef struct packed {
    logic [OPD_W-1:0] a;
    logic [OPD_W-1:0] b;
    logic [OPD_W-1:0] c;
    logic             op;
  } fp_mac_in_type;
  typedef struct packed {
    logic [RES_W-1:0] d;
  } fp_mac_out_type;
endpackage

// File: rtl/fp_mac_arb_mac.sv
// fp_mac: combinational {a,0} +/- signed(b)*signed(c), wrapped to the result width
module fp_mac
  import fp_wire::*;
(
  input  fp_mac_in_type  mac_i,
  output fp_mac_out_type mac_o
);
  logic signed [2*OPD_W-1:0] mul;
  logic [RES_W-1:0] mac;
  // full signed product, low bits optionally negated, then added to the shifted addend
  always_comb begin
    mul = $signed(mac_i.b) * $signed(mac_i.c);
    mac = mac_i.op ? -mul[RES_W-1:0] : mul[RES_W-1:0];
    mac_o.d = {mac_i.a, {SHF_W{1'b0}}} + mac;
  end
endmodule

// File: rtl/fp_mac_arb.sv
// fp_mac_arb: two-requester arbiter feeding a two-stage multiply-accumulate pipeline
module fp_mac_arb
  import fp_wire::*;
#(
  parameter int FAIR = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [OPD_W-1:0] req_a0,
  input  logic [OPD_W-1:0] req_a1,
  input  logic [OPD_W-1:0] req_b0,
  input  logic [OPD_W-1:0] req_b1,
  input  logic [OPD_W-1:0] req_c0,
  input  logic [OPD_W-1:0] req_c1,
  input  logic [1:0]       req_op,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [RES_W-1:0] rsp_d,
  output logic             busy
);
  arb_req_t s1_q, s1_d, req_sel;
  logic s1_own_q, s1_own_d;
  logic s2_v_q, s2_v_d, s2_own_q, s2_own_d;
  logic [RES_W-1:0] s2_res_q, s2_res_d;
  logic ptr_q, ptr_d;
  logic s2_drain, s1_adv, s1_load, sel, acc;
  fp_mac_in_type mac_in;
  fp_mac_out_type mac_out;

  fp_mac u_mac (
    .mac_i(mac_in),
    .mac_o(mac_out)
  );

  // handshake chain: S2 drain frees S1, S1 advance frees the request slot; reset blocks grants
  always_comb begin
    s2_drain = s2_v_q & rsp_ready[s2_own_q];
    s1_adv = s1_q.valid & (~s2_v_q | s2_drain);
    s1_load = ~s1_q.valid | s1_adv;
    sel = (&req_valid) ? ((FAIR != 0) & ptr_q) : req_valid[1];
    acc = (|req_valid) & s1_load & ~reset;
    req_ready = acc ? (sel ? 2'b10 : 2'b01) : 2'b00;
    req_sel.valid = 1'b1;
    req_sel.a = sel ? req_a1 : req_a0;
    req_sel.b = sel ? req_b1 : req_b0;
    req_sel.c = sel ? req_c1 : req_c0;
    req_sel.op = sel ? req_op[1] : req_op[0];
    mac_in.a = s1_q.a;
    mac_in.b = s1_q.b;
    mac_in.c = s1_q.c;
    mac_in.op = s1_q.op;
  end

  // next state for both stages and the round-robin pointer
  always_comb begin
    s1_d = s1_q;
    s1_own_d = s1_own_q;
    if (acc) begin
      s1_d = req_sel;
      s1_own_d = sel;
    end else if (s1_adv) begin
      s1_d.valid = 1'b0;
    end
    s2_v_d = s1_adv | (s2_v_q & ~s2_drain);
    s2_own_d = s1_adv ? s1_own_q : s2_own_q;
    s2_res_d = s1_adv ? mac_out.d : s2_res_q;
    ptr_d = (acc && FAIR != 0) ? ~sel : ptr_q;
  end

  // outputs are gated by reset so they fall immediately, not at the next edge
  always_comb begin
    rsp_valid = (s2_v_q & ~reset) ? (s2_own_q ? 2'b10 : 2'b01) : 2'b00;
    rsp_d = s2_res_q;
    busy = (s1_q.valid | s2_v_q) & ~reset;
  end

  // pipeline and pointer registers; reset discards in-flight work
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_q <= '0;
      s1_own_q <= 1'b0;
      s2_v_q <= 1'b0;
      s2_own_q <= 1'b0;
      s2_res_q <= '0;
      ptr_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s1_own_q <= s1_own_d;
      s2_v_q <= s2_v_d;
      s2_own_q <= s2_own_d;
      s2_res_q <= s2_res_d;
      ptr_q <= ptr_d;
    end
  end
endmodule

// File: tb/tb_fp_mac_arb.sv
// tb_fp_mac_arb: scoreboard bench for the arbitrated MAC pipeline (round-robin and fixed-priority builds)
module tb_fp_mac_arb;
  import fp_wire::*;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [1:0] req_valid = 2'b00;
  logic [1:0] rsp_ready = 2'b00;
  logic [1:0] req_op = 2'b00;
  logic [55:0] a0 = '0, a1 = '0, b0 = '0, b1 = '0, c0 = '0, c1 = '0;
  logic [109:0] exp0 = '0, exp1 = '0;
  logic [1:0] rdy_r, rv_r, rdy_f, rv_f, rdy, rv;
  logic [109:0] rd_r, rd_f, rd;
  logic busy_r, busy_f, bsy;
  bit mode = 1'b0;
  int total = 0;
  int bad = 0;
  logic [110:0] sb[$];
  logic [110:0] e;

  always #5 clock = ~clock;

  fp_mac_arb #(.FAIR(1)) u_rr (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(rdy_r),
    .req_a0(a0), .req_a1(a1), .req_b0(b0), .req_b1(b1), .req_c0(c0), .req_c1(c1),
    .req_op(req_op), .rsp_valid(rv_r), .rsp_ready(rsp_ready), .rsp_d(rd_r), .busy(busy_r)
  );

  fp_mac_arb #(.FAIR(0)) u_fix (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(rdy_f),
    .req_a0(a0), .req_a1(a1), .req_b0(b0), .req_b1(b1), .req_c0(c0), .req_c1(c1),
    .req_op(req_op), .rsp_valid(rv_f), .rsp_ready(rsp_ready), .rsp_d(rd_f), .busy(busy_f)
  );

  always_comb begin
    rdy = mode ? rdy_f : rdy_r;
    rv = mode ? rv_f : rv_r;
    rd = mode ? rd_f : rd_r;
    bsy = mode ? busy_f : busy_r;
  end

  task automatic chk(input string nm, input logic [111:0] act, input logic [111:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h @%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [109:0] fk(input int k);
    return (110'(k + 1) << 54) + 110'(k + 1);
  endfunction

  // monitor: log acceptances as expected responses, pop and compare on each delivered response
  always @(negedge clock) begin
    if (!reset) begin
      chk("ready_onehot", 112'($countones(rdy) <= 1), 112'd1);
      if (req_valid[0] & rdy[0]) sb.push_back({1'b0, exp0});
      if (req_valid[1] & rdy[1]) sb.push_back({1'b1, exp1});
      if ((rv & rsp_ready) != 2'b00) begin
        if (sb.size() == 0) chk("unexpected_rsp", 112'(rv), 112'd0);
        else begin
          e = sb.pop_front();
          chk("rsp_owner", 112'(rv), e[110] ? 112'd2 : 112'd1);
          chk("rsp_d", 112'(rd), 112'(e[109:0]));
        end
      end
    end
  end

  task automatic drive(input int i, input logic [55:0] a, input logic [55:0] b,
                       input logic [55:0] c, input logic op, input logic [109:0] x);
    if (i == 0) begin
      a0 = a; b0 = b; c0 = c; req_op[0] = op; exp0 = x;
    end else begin
      a1 = a; b1 = b; c1 = c; req_op[1] = op; exp1 = x;
    end
    req_valid[i] = 1'b1;
  endtask

  task automatic send(input int i, input logic [55:0] a, input logic [55:0] b,
                      input logic [55:0] c, input logic op, input logic [109:0] x);
    bit ok = 1'b0;
    drive(i, a, b, c, op, x);
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clock);
      ok = rdy[i];
    end
    chk("send_grant", 112'(ok), 112'd1);
    @(posedge clock);
    #1 req_valid[i] = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int n = 0; n < 60 && !ok; n++) begin
      @(negedge clock);
      ok = (sb.size() == 0) && !bsy;
    end
    chk("drain_idle", 112'(ok), 112'd1);
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    sb.delete();
    req_valid = 2'b00;
    #12 reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bit acc;
    rsp_ready = 2'b11;
    req_valid = 2'b11;
    #3;
    chk("rst_ready", 112'(rdy), 112'd0);
    chk("rst_rsp_valid", 112'(rv), 112'd0);
    chk("rst_busy", 112'(bsy), 112'd0);
    req_valid = 2'b00;
    #10 reset = 1'b0;
    @(posedge clock);
    #1;
    // single request, exact latency
    drive(0, 56'd1, 56'd2, 56'd3, 1'b0, 110'h40000000000006);
    @(negedge clock);
    chk("t1_ready", 112'(rdy), 112'd1);
    @(posedge clock);
    #1 req_valid[0] = 1'b0;
    @(negedge clock);
    chk("t1_lat_n1", 112'(rv), 112'd0);
    @(negedge clock);
    chk("t1_lat_n2", 112'(rv), 112'd1);
    chk("t1_d", 112'(rd), 112'h40000000000006);
    wait_idle();
    // subtract and signed operand
    send(0, 56'd1, 56'd2, 56'd3, 1'b1, 110'h3FFFFFFFFFFFFA);
    send(0, 56'd1, '1, 56'd1, 1'b0, 110'h3FFFFFFFFFFFFF);
    wait_idle();
    // round-robin under contention
    pulse_reset();
    drive(0, 56'd2, 56'd1, 56'd1, 1'b0, 110'h80000000000001);
    drive(1, 56'd3, '1, 56'd2, 1'b1, 110'hC0000000000002);
    for (int j = 0; j < 6; j++) begin
      @(negedge clock);
      chk("rr_grant", 112'(rdy), (j % 2) ? 112'd2 : 112'd1);
      if (j >= 2) chk("rr_rsp", 112'(rv), (j % 2) ? 112'd2 : 112'd1);
    end
    @(posedge clock);
    #1 req_valid = 2'b00;
    wait_idle();
    // backpressure on requester 0
    rsp_ready = 2'b10;
    k = 0;
    drive(0, 56'd1, 56'd1, 56'd1, 1'b0, fk(0));
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clock);
      if (cyc >= 2 && cyc < 5) begin
        chk("bp_ready", 112'(rdy), 112'd0);
        chk("bp_hold_d", 112'(rd), 112'(fk(0)));
        chk("bp_hold_valid", 112'(rv), 112'd1);
        chk("bp_busy", 112'(bsy), 112'd1);
      end
      if (cyc == 4) chk("bp_inflight", 112'(k), 112'd2);
      acc = req_valid[0] & rdy[0];
      @(posedge clock);
      #1;
      if (acc) k++;
      if (k >= 4) req_valid[0] = 1'b0;
      else drive(0, 56'(k + 1), 56'(k + 1), 56'd1, 1'b0, fk(k));
      if (cyc == 4) rsp_ready = 2'b11;
    end
    chk("bp_count", 112'(k), 112'd4);
    wait_idle();
    // fixed priority build
    mode = 1'b1;
    pulse_reset();
    drive(0, 56'd1, 56'd2, 56'd3, 1'b0, 110'h40000000000006);
    drive(1, 56'd3, '1, 56'd2, 1'b1, 110'hC0000000000002);
    for (int j = 0; j < 4; j++) begin
      @(negedge clock);
      chk("fix_grant0", 112'(rdy), 112'd1);
    end
    @(posedge clock);
    #1 req_valid[0] = 1'b0;
    @(negedge clock);
    chk("fix_grant1", 112'(rdy), 112'd2);
    @(posedge clock);
    #1 req_valid[1] = 1'b0;
    wait_idle();
    // reset mid-operation with both stages full
    mode = 1'b0;
    pulse_reset();
    rsp_ready = 2'b00;
    drive(0, 56'd1, 56'd2, 56'd3, 1'b0, 110'h40000000000006);
    for (int j = 0; j < 3; j++) @(negedge clock);
    chk("mid_busy", 112'(bsy), 112'd1);
    chk("mid_rsp_valid", 112'(rv), 112'd1);
    chk("mid_ready", 112'(rdy), 112'd0);
    #2 reset = 1'b1;
    #1;
    chk("async_rsp_valid", 112'(rv), 112'd0);
    chk("async_busy", 112'(bsy), 112'd0);
    chk("async_ready", 112'(rdy), 112'd0);
    sb.delete();
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    #10 reset = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clock);
      chk("post_rst_rsp", 112'(rv), 112'd0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
